bcd_mod_counter: RTL and testbench

Parametrised synchronous BCD modulo counter with up/down counting, count enable, parallel load with validity checking, and a cascade carry/borrow output. It is the general counting element for the clock datapath. Typical instances are seconds/minutes (MODULUS=60), hours (MODULUS=24 or 12), and wider BCD event counters. Instances chain through `cout` into the next stage's `en` with no added latency.

---
 rtl/bcd_mod_counter_if.sv | 28 ++
 rtl/bcd_mod_counter.sv | 106 ++++++++++
 tb/tb_bcd_mod_counter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_mod_counter_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter_if
// Brief    : Control/data bundle of one BCD modulo counter stage.
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_mod_counter_if #(
   parameter int DIGITS = 2
);
   logic                  en;
   logic                  up;
   logic                  load;
   logic [4*DIGITS-1:0]   din;
   logic [4*DIGITS-1:0]   qout;
   logic                  cout;
   logic                  err;

   modport master (
      output en, up, load, din,
      input  qout, cout, err
   );

   modport slave (
      input  en, up, load, din,
      output qout, cout, err
   );
endinterface : bcd_mod_counter_if
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_counter
// Brief    : Up/down BCD modulo counter with checked parallel load and cascade.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_mod_counter #(
   parameter int DIGITS  = 2,
   parameter int MODULUS = 60
) (
   input  wire logic        clk,
   input  wire logic        reset,
   bcd_mod_counter_if.slave bus
);

   localparam int c_WIDTH = 4 * DIGITS;

   function automatic logic [c_WIDTH-1:0] f_to_bcd(input int value);
      logic [c_WIDTH-1:0] r;
      int                 v;
      r = '0;
      v = value;
      for (int k = 0; k < DIGITS; k++) begin
         r[4*k +: 4] = 4'(v % 10);
         v           = v / 10;
      end
      return r;
   endfunction

   localparam logic [c_WIDTH-1:0] c_MAX_BCD = f_to_bcd(MODULUS - 1);

   if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
      $fatal(1, "bcd_mod_counter: DIGITS=%0d outside 1..4", DIGITS);
   end
   if (MODULUS < 2 || MODULUS > 10**DIGITS) begin : g_bad_modulus
      $fatal(1, "bcd_mod_counter: MODULUS=%0d outside 2..10^DIGITS", MODULUS);
   end

   logic [c_WIDTH-1:0] r_qout;
   logic               r_err;

   logic [DIGITS-1:0]  w_carry;
   logic [DIGITS-1:0]  w_borrow;
   logic [DIGITS-1:0]  w_digit_ok;
   logic [c_WIDTH-1:0] w_inc;
   logic [c_WIDTH-1:0] w_dec;
   logic [c_WIDTH-1:0] w_step;
   logic               w_at_max;
   logic               w_at_zero;
   logic               w_din_ok;

   assign w_carry[0]  = 1'b1;
   assign w_borrow[0] = 1'b1;

   // Ripple carry/borrow strictly digit by digit; no binary intermediate.
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      logic [3:0] w_d;
      assign w_d = r_qout[4*k +: 4];

      assign w_inc[4*k +: 4] = !w_carry[k]  ? w_d :
                               (w_d == 4'd9) ? 4'd0 : w_d + 4'd1;
      assign w_dec[4*k +: 4] = !w_borrow[k] ? w_d :
                               (w_d == 4'd0) ? 4'd9 : w_d - 4'd1;

      assign w_digit_ok[k] = (bus.din[4*k +: 4] <= 4'd9);

      if (k < DIGITS - 1) begin : g_chain
         assign w_carry[k+1]  = w_carry[k]  & (w_d == 4'd9);
         assign w_borrow[k+1] = w_borrow[k] & (w_d == 4'd0);
      end
   end

   assign w_at_max  = (r_qout == c_MAX_BCD);
   assign w_at_zero = (r_qout == '0);

   // With every digit legal, packed BCD orders the same as its decimal value.
   assign w_din_ok  = (&w_digit_ok) && (bus.din <= c_MAX_BCD);

   assign w_step = bus.up ? (w_at_max  ? '0        : w_inc)
                          : (w_at_zero ? c_MAX_BCD : w_dec);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_qout <= '0;
         r_err  <= 1'b0;
      end else if (bus.load) begin
         if (w_din_ok) begin
            r_qout <= bus.din;
            r_err  <= 1'b0;
         end else begin
            r_err  <= 1'b1;
         end
      end else begin
         r_err <= 1'b0;
         if (bus.en) begin
            r_qout <= w_step;
         end
      end
   end

   assign bus.qout = r_qout;
   assign bus.err  = r_err;
   assign bus.cout = bus.en & ~bus.load & ~reset & (bus.up ? w_at_max : w_at_zero);

endmodule : bcd_mod_counter
`default_nettype wire

// File: tb/tb_bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_mod_counter
// Brief    : Scoreboard bench: mod-60, mod-24 and a 60->60->24 cascade.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_mod_counter;

   typedef struct packed {
      logic [39:0] q;
      logic [4:0]  err;
      logic [4:0]  cout;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bcd_mod_counter_if #(.DIGITS(2)) a_if ();
   bcd_mod_counter_if #(.DIGITS(2)) b_if ();
   bcd_mod_counter_if #(.DIGITS(2)) c0_if ();
   bcd_mod_counter_if #(.DIGITS(2)) c1_if ();
   bcd_mod_counter_if #(.DIGITS(2)) c2_if ();

   bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_a  (.clk(clk), .reset(reset), .bus(a_if.slave));
   bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_b  (.clk(clk), .reset(reset), .bus(b_if.slave));
   bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_c0 (.clk(clk), .reset(reset), .bus(c0_if.slave));
   bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_c1 (.clk(clk), .reset(reset), .bus(c1_if.slave));
   bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_c2 (.clk(clk), .reset(reset), .bus(c2_if.slave));

   assign c1_if.en = c0_if.cout;
   assign c2_if.en = c1_if.cout;

   // Stimulus per stage: 0=a, 1=b, 2..4=cascade (en of 3,4 comes from cout).
   int         modv [5] = '{60, 24, 60, 60, 24};
   int         mv   [5] = '{0, 0, 0, 0, 0};
   logic       in_en   [5];
   logic       in_up   [5];
   logic       in_load [5];
   logic [7:0] in_din  [5];
   logic       in_reset;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      for (int i = 0; i < 5; i++) begin
         in_en[i] = 1'b0; in_up[i] = 1'b1; in_load[i] = 1'b0; in_din[i] = 8'h00;
      end
      in_reset = 1'b0;
   endtask

   // One cycle: apply inputs, run the reference model, queue the expectation.
   task automatic tick();
      exp_t e;
      logic ce [5];
      logic en_eff;
      int   hi, lo;
      @(negedge clk);
      reset = in_reset;
      a_if.en  = in_en[0]; a_if.up  = in_up[0]; a_if.load  = in_load[0]; a_if.din  = in_din[0];
      b_if.en  = in_en[1]; b_if.up  = in_up[1]; b_if.load  = in_load[1]; b_if.din  = in_din[1];
      c0_if.en = in_en[2]; c0_if.up = in_up[2]; c0_if.load = in_load[2]; c0_if.din = in_din[2];
      c1_if.up = in_up[3]; c1_if.load = in_load[3]; c1_if.din = in_din[3];
      c2_if.up = in_up[4]; c2_if.load = in_load[4]; c2_if.din = in_din[4];
      e = '0;
      for (int i = 0; i < 5; i++) begin
         en_eff = (i < 3) ? in_en[i] : ce[i-1];
         ce[i]  = en_eff && !in_load[i] && !in_reset &&
                  (in_up[i] ? (mv[i] == modv[i] - 1) : (mv[i] == 0));
         e.cout[i] = ce[i];
         if (in_reset) begin
            mv[i] = 0; e.err[i] = 1'b0;
         end else if (in_load[i]) begin
            hi = int'(in_din[i][7:4]);
            lo = int'(in_din[i][3:0]);
            if (hi <= 9 && lo <= 9 && (hi * 10 + lo) < modv[i]) begin
               mv[i] = hi * 10 + lo; e.err[i] = 1'b0;
            end else begin
               e.err[i] = 1'b1;
            end
         end else begin
            e.err[i] = 1'b0;
            if (en_eff) mv[i] = in_up[i] ? (mv[i] + 1) % modv[i]
                                         : (mv[i] + modv[i] - 1) % modv[i];
         end
         e.q[8*i +: 8] = to_bcd(mv[i]);
      end
      sbq.push_back(e);
   endtask

   // Monitor: cout mid-cycle, registered outputs just after the edge.
   initial begin
      exp_t       e;
      logic [39:0] aq;
      logic [4:0]  ae, ac;
      forever begin
         @(negedge clk);
         #3;
         if (sbq.size() > 0) begin
            e  = sbq.pop_front();
            ac = {c2_if.cout, c1_if.cout, c0_if.cout, b_if.cout, a_if.cout};
            for (int i = 0; i < 5; i++)
               check($sformatf("cout[%0d]", i), {7'd0, ac[i]}, {7'd0, e.cout[i]});
            @(posedge clk);
            #1;
            aq = {c2_if.qout, c1_if.qout, c0_if.qout, b_if.qout, a_if.qout};
            ae = {c2_if.err, c1_if.err, c0_if.err, b_if.err, a_if.err};
            for (int i = 0; i < 5; i++) begin
               check($sformatf("qout[%0d]", i), aq[8*i +: 8], e.q[8*i +: 8]);
               check($sformatf("err[%0d]", i), {7'd0, ae[i]}, {7'd0, e.err[i]});
            end
         end
      end
   end

   initial begin
      idle();
      in_reset = 1'b1;
      a_if.en = 0; a_if.up = 1; a_if.load = 0; a_if.din = 0;
      b_if.en = 0; b_if.up = 1; b_if.load = 0; b_if.din = 0;
      c0_if.en = 0; c0_if.up = 1; c0_if.load = 0; c0_if.din = 0;
      c1_if.up = 1; c1_if.load = 0; c1_if.din = 0;
      c2_if.up = 1; c2_if.load = 0; c2_if.din = 0;
      repeat (2) tick();
      idle();

      // Up wrap on the mod-60 stage
      in_en[0] = 1'b1;
      repeat (61) tick();
      idle();

      // Down wrap on mod-24, then up across 19->20 and 23->00
      in_load[1] = 1'b1; in_din[1] = 8'h01; tick(); idle();
      in_en[1] = 1'b1; in_up[1] = 1'b0; repeat (4) tick(); idle();
      in_load[1] = 1'b1; in_din[1] = 8'h19; tick(); idle();
      in_en[1] = 1'b1; tick(); idle();
      in_load[1] = 1'b1; in_din[1] = 8'h23; tick(); idle();
      in_en[1] = 1'b1; tick(); idle();

      // Load validation
      in_load[0] = 1'b1; in_din[0] = 8'h45; tick();
      in_din[0] = 8'h4A; tick(); idle(); tick();
      in_load[0] = 1'b1; in_din[0] = 8'h60; tick(); idle(); tick();
      in_load[0] = 1'b1; in_en[0] = 1'b1; in_din[0] = 8'h12; tick(); idle();

      // Reset beats load and enable
      in_load[0] = 1'b1; in_din[0] = 8'h37; tick(); idle();
      in_reset = 1'b1; in_load[0] = 1'b1; in_din[0] = 8'h05; in_en[0] = 1'b1; tick(); idle();

      // Hold, then count down from 59
      in_load[0] = 1'b1; in_din[0] = 8'h59; tick(); idle();
      repeat (5) tick();
      in_en[0] = 1'b1; in_up[0] = 1'b1; tick();
      in_load[0] = 1'b1; in_din[0] = 8'h59; in_en[0] = 1'b0; tick(); idle();
      in_en[0] = 1'b1; in_up[0] = 1'b0; tick(); idle();

      // Cascade wrap 23:59:59 -> 00:00:00
      in_load[2] = 1'b1; in_din[2] = 8'h59;
      in_load[3] = 1'b1; in_din[3] = 8'h59;
      in_load[4] = 1'b1; in_din[4] = 8'h23; tick(); idle();
      in_en[2] = 1'b1; tick(); idle(); tick();

      // Randomised traffic on every stage
      for (int n = 0; n < 600; n++) begin
         idle();
         in_reset = ($urandom_range(0, 79) == 0);
         for (int i = 0; i < 5; i++) begin
            in_en[i]   = ($urandom_range(0, 3) != 0);
            in_up[i]   = ($urandom_range(0, 2) != 0);
            in_load[i] = ($urandom_range(0, 9) == 0);
            in_din[i]  = $urandom_range(0, 1) ? to_bcd($urandom_range(0, modv[i] - 1))
                                              : 8'($urandom);
         end
         tick();
      end
      idle();
      tick();
      repeat (3) @(posedge clk);
      check("sb_drain", 8'(sbq.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_bcd_mod_counter
`default_nettype wire
